redmule_job_queue: RTL and testbench
====================================

Name: redmule_job_queue

Overview:
Multi-core job front-end for the RedMulE accelerator. Accepts job configurations from N_CORES requesters and round-robin arbitrates between them. Buffers up to N_CONTEXT pending jobs in order and hands them one at a time to the RedMulE controller through its start/config interface. Tracks the running job and returns a completion event to the core that submitted it.

Parameters:
N_CORES, 8, number of requesting cores.
N_CONTEXT, 2, job-queue depth (pending jobs, excluding the running one); must be >= 1.
ID_WIDTH, 8, job identifier width.
CfgWidth, 256, width of a flattened job configuration word.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
clear_i  in  1  synchronous soft clear.
req_valid_i  in  N_CORES  per-core job-submit valid.
req_ready_o  out  N_CORES  per-core accept (one-hot or zero).
req_cfg_i  in  N_CORES x CfgWidth  per-core job configuration.
req_id_o  out  ID_WIDTH  ID assigned to the job accepted this cycle.
start_cfg_o  out  1  one-cycle start pulse to the controller.
cfg_o  out  CfgWidth  configuration of the head/running job.
cfg_complete_i  in  1  controller has latched the configuration (tiler valid).
busy_i  in  1  controller busy.
finished_i  in  1  controller finished pulse.
evt_o  out  N_CORES x 2  per-core events: [0] job done, [1] job accepted.
running_o  out  1  a job is issued and not yet finished.
running_id_o  out  ID_WIDTH  ID of the head job.
occupancy_o  out  $clog2(N_CONTEXT+2)  number of queued jobs, including the running one.

Behaviour:
- Reset / clear_i values: all outputs 0, queue empty, ID counter 0, RR pointer 0, FSM IDLE. clear_i has priority over every other event in the same cycle.
- Storage: FIFO of N_CONTEXT+1 entries {cfg, id, owner}. The head entry is the issued/running job and is popped only at DONE.
- Accept:
  - req_ready_o is asserted to the RR winner among req_valid_i, only when occupancy < N_CONTEXT+1 (registered count, no bypass).
  - At most one accept per cycle.
  - The RR pointer moves to winner+1 mod N_CORES after each accept.
- On accept:
  - req_id_o equals the ID counter; the counter then increments and wraps 2^ID_WIDTH-1 -> 0.
  - evt_o[winner][1] pulses in the same cycle.
- FSM:
  - IDLE: if the FIFO is non-empty and busy_i=0 -> ISSUE.
  - ISSUE: start_cfg_o=1 for exactly this cycle, cfg_o = head cfg -> WAIT.
  - WAIT: stay until cfg_complete_i=1 and busy_i=1 -> RUN. Re-pulse start_cfg_o if 16 cycles pass without busy_i.
  - RUN: running_o=1. On finished_i -> DONE.
  - DONE: pop the head; evt_o[head owner][0]=1 for one cycle -> IDLE.
- running_o is 1 in ISSUE, WAIT and RUN.
- cfg_o and running_id_o stay stable from ISSUE through DONE.
- A push and a pop in the same cycle are both honoured; occupancy stays unchanged.
- finished_i outside RUN is ignored.
- Minimum gap between two jobs: DONE -> IDLE -> ISSUE, i.e. 2 idle cycles after finished_i.
- clear_i mid-job drops all queued jobs with no done events. The controller is expected to be cleared in parallel.

Decomposition:
- The shared redmule_pkg gains redmule_job_t {cfg, id, owner} and the constants JOB_EVT_DONE=0, JOB_EVT_ACC=1.
- Sub-module redmule_job_fifo: parametric-depth FIFO with push/pop, full/empty and count outputs.
- Arbitration stays inline as a simple RR pointer.

Test Plan:
- Single job: core 3 submits with busy_i=0.
  - req_ready_o=8'b0000_1000, req_id_o=0, evt_o[3][1] pulse.
  - start_cfg_o exactly 2 cycles later.
  - finished_i -> evt_o[3][0] pulse one cycle later.
- Fairness: cores 0, 1, 2 hold valid continuously with a stalled controller.
  - Accept order is 0, 1, 2 until full (3 jobs), then all ready_o=0.
  - First pop frees one slot and core 0 wins the next accept.
- Full boundary: occupancy=3 and a new request in the DONE cycle.
  - Pop and push both occur; occupancy stays 3.
  - The ID increments without gaps.
- ID wrap: 256 jobs submitted -> job 256 gets req_id_o=0.
- No handshake: busy_i held 0 in WAIT -> start_cfg_o re-pulses at cycle 16 of WAIT; no further start pulse once busy_i and cfg_complete_i are asserted.
- Clear: clear_i during RUN with 2 queued jobs.
  - Next cycle occupancy_o=0, running_o=0, no evt_o.
  - Later finished_i is ignored.

Source files
------------

// File: rtl/redmule_job_queue_pkg.sv
// Shared types and constants for the RedMulE multi-core job front-end.
package redmule_job_queue_pkg;

    localparam int unsigned JOB_EVT_DONE = 0;
    localparam int unsigned JOB_EVT_ACC  = 1;

    // Cycles spent in WAIT without busy_i before start_cfg_o is pulsed again.
    localparam int unsigned WAIT_RETRY_CYCLES = 16;

    localparam int unsigned DEF_CFG_W   = 256;
    localparam int unsigned DEF_ID_W    = 8;
    localparam int unsigned DEF_OWNER_W = 3;

    typedef struct packed {
        logic [DEF_CFG_W-1:0]   cfg;
        logic [DEF_ID_W-1:0]    id;
        logic [DEF_OWNER_W-1:0] owner;
    } redmule_job_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } job_state_e;

endpackage

// File: rtl/redmule_job_fifo.sv
// In-order job buffer; the head entry stays visible until it is explicitly popped.
module redmule_job_fifo
    import redmule_job_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter type         job_t = redmule_job_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  job_t                       data_i,
    input  logic                       pop_i,
    output job_t                       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CntWidth = $clog2(DEPTH + 1);
    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    job_t                mem_q [DEPTH];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_o == CntWidth'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle;
    // the new entry overwrites the slot being vacated, which becomes the tail.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_o <= count_o + 1'b1;
            else if (!do_push && do_pop) count_o <= count_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/redmule_job_queue.sv
// Multi-core job front-end: round-robin accept, in-order queue, and a start/track
// FSM driving the RedMulE controller with per-core accept/done events.
module redmule_job_queue
    import redmule_job_queue_pkg::*;
#(
    parameter int unsigned N_CORES   = 8,
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned ID_WIDTH  = 8,
    parameter int unsigned CfgWidth  = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic [N_CORES-1:0]                   req_valid_i,
    output logic [N_CORES-1:0]                   req_ready_o,
    input  logic [N_CORES-1:0][CfgWidth-1:0]     req_cfg_i,
    output logic [ID_WIDTH-1:0]                  req_id_o,
    output logic                                 start_cfg_o,
    output logic [CfgWidth-1:0]                  cfg_o,
    input  logic                                 cfg_complete_i,
    input  logic                                 busy_i,
    input  logic                                 finished_i,
    output logic [N_CORES-1:0][1:0]              evt_o,
    output logic                                 running_o,
    output logic [ID_WIDTH-1:0]                  running_id_o,
    output logic [$clog2(N_CONTEXT+2)-1:0]       occupancy_o
);

    localparam int unsigned Depth      = N_CONTEXT + 1;
    localparam int unsigned OwnerWidth = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned CandWidth  = OwnerWidth + 1;
    localparam int unsigned RetryWidth = $clog2(WAIT_RETRY_CYCLES);

    typedef struct packed {
        logic [CfgWidth-1:0]   cfg;
        logic [ID_WIDTH-1:0]   id;
        logic [OwnerWidth-1:0] owner;
    } job_t;

    job_state_e            state_q;
    logic [OwnerWidth-1:0] rr_ptr_q;
    logic [OwnerWidth-1:0] win_idx;
    logic [CandWidth-1:0]  cand;
    logic                  win_found;
    logic                  accept;
    logic [ID_WIDTH-1:0]   id_cnt_q;
    logic [N_CORES-1:0]    done_evt_q;
    logic [RetryWidth-1:0] retry_cnt_q;
    job_t                  push_job;
    job_t                  head_job;
    logic                  fifo_full;
    logic                  fifo_empty;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_CORES; i++) begin
            cand = {1'b0, rr_ptr_q} + CandWidth'(i);
            if (cand >= CandWidth'(N_CORES)) cand = cand - CandWidth'(N_CORES);
            if (!win_found && req_valid_i[cand[OwnerWidth-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OwnerWidth-1:0];
            end
        end
    end

    // The DONE cycle frees the head slot, so a full queue may accept alongside the pop.
    assign accept   = win_found & ~clear_i & (~fifo_full | (state_q == ST_DONE));
    assign req_id_o = id_cnt_q;
    assign push_job = '{cfg: req_cfg_i[win_idx], id: id_cnt_q, owner: win_idx};

    always_comb begin
        req_ready_o = '0;
        evt_o       = '0;
        for (int c = 0; c < N_CORES; c++) evt_o[c][JOB_EVT_DONE] = done_evt_q[c];
        if (accept) begin
            req_ready_o[win_idx]          = 1'b1;
            evt_o[win_idx][JOB_EVT_ACC]   = 1'b1;
        end
    end

    redmule_job_fifo #(
        .DEPTH (Depth),
        .job_t (job_t)
    ) i_job_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (accept),
        .data_i  (push_job),
        .pop_i   (state_q == ST_DONE),
        .data_o  (head_job),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            id_cnt_q <= '0;
        end else if (clear_i) begin
            rr_ptr_q <= '0;
            id_cnt_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (win_idx == OwnerWidth'(N_CORES - 1)) ? '0 : win_idx + 1'b1;
            id_cnt_q <= id_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            start_cfg_o  <= 1'b0;
            running_o    <= 1'b0;
            cfg_o        <= '0;
            running_id_o <= '0;
            done_evt_q   <= '0;
            retry_cnt_q  <= '0;
        end else if (clear_i) begin
            state_q      <= ST_IDLE;
            start_cfg_o  <= 1'b0;
            running_o    <= 1'b0;
            cfg_o        <= '0;
            running_id_o <= '0;
            done_evt_q   <= '0;
            retry_cnt_q  <= '0;
        end else begin
            start_cfg_o <= 1'b0;
            done_evt_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && !busy_i) begin
                        state_q      <= ST_ISSUE;
                        start_cfg_o  <= 1'b1;
                        running_o    <= 1'b1;
                        cfg_o        <= head_job.cfg;
                        running_id_o <= head_job.id;
                    end
                end
                ST_ISSUE: begin
                    state_q     <= ST_WAIT;
                    retry_cnt_q <= RetryWidth'(1);
                end
                ST_WAIT: begin
                    // retry_cnt_q counts cycles since the last start pulse.
                    if (cfg_complete_i && busy_i) begin
                        state_q <= ST_RUN;
                    end else if (busy_i) begin
                        retry_cnt_q <= '0;
                    end else if (retry_cnt_q == RetryWidth'(WAIT_RETRY_CYCLES - 1)) begin
                        start_cfg_o <= 1'b1;
                        retry_cnt_q <= '0;
                    end else begin
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (finished_i) begin
                        state_q                    <= ST_DONE;
                        running_o                  <= 1'b0;
                        done_evt_q[head_job.owner] <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_job_queue.sv
// Directed bench for redmule_job_queue: single job, RR fairness, full push/pop,
// start retry, soft clear and ID wrap.
module tb_redmule_job_queue;

    localparam int NC  = 8;
    localparam int NX  = 2;
    localparam int IDW = 8;
    localparam int CW  = 256;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clear = 1'b0;
    logic                   cfg_complete = 1'b0;
    logic                   busy = 1'b0;
    logic                   finished = 1'b0;
    logic [NC-1:0]          req_valid = '0;
    logic [NC-1:0]          req_ready;
    logic [NC-1:0][CW-1:0]  req_cfg;
    logic [IDW-1:0]         req_id;
    logic [IDW-1:0]         running_id;
    logic                   start_cfg;
    logic                   running;
    logic [CW-1:0]          cfg;
    logic [NC-1:0][1:0]     evt;
    logic [$clog2(NX+2)-1:0] occupancy;
    logic                   seen_start;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    redmule_job_queue #(
        .N_CORES   (NC),
        .N_CONTEXT (NX),
        .ID_WIDTH  (IDW),
        .CfgWidth  (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_cfg_i      (req_cfg),
        .req_id_o       (req_id),
        .start_cfg_o    (start_cfg),
        .cfg_o          (cfg),
        .cfg_complete_i (cfg_complete),
        .busy_i         (busy),
        .finished_i     (finished),
        .evt_o          (evt),
        .running_o      (running),
        .running_id_o   (running_id),
        .occupancy_o    (occupancy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full job from an idle, empty queue: accept, issue, handshake, finish, drain.
    task automatic run_job(input logic [NC-1:0] mask, input logic [NC-1:0] exp_rdy,
                           input logic [IDW-1:0] exp_id, input bit chk_rdy, input string tag);
        req_valid = mask;
        #1;
        if (chk_rdy) check("rr_after_clear", 256'(req_ready), 256'(exp_rdy));
        check(tag, 256'(req_id), 256'(exp_id));
        step();
        req_valid = '0;
        step(2);
        busy = 1'b1;
        cfg_complete = 1'b1;
        step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        busy = 1'b0;
        cfg_complete = 1'b0;
        step();
        #1;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) req_cfg[i] = {8{32'(32'hC0DE_0000 + i)}};

        step(3);
        check("rst_ready", 256'(req_ready), '0);
        check("rst_start", 256'(start_cfg), '0);
        check("rst_running", 256'(running), '0);
        check("rst_occ", 256'(occupancy), '0);
        check("rst_evt", 256'(evt), '0);
        check("rst_cfg", cfg, '0);
        check("rst_id", 256'(req_id), '0);
        rst_n = 1'b1;
        step();

        // Single job from core 3
        req_valid = 8'h08;
        #1;
        check("acc_ready", 256'(req_ready), 256'(8'h08));
        check("acc_id", 256'(req_id), '0);
        check("acc_evt", 256'(evt), 256'(16'h0080));
        step();
        req_valid = '0;
        #1;
        check("occ_one", 256'(occupancy), 256'(1));
        check("no_start_early", 256'(start_cfg), '0);
        step();
        #1;
        check("start_pulse", 256'(start_cfg), 256'(1));
        check("running_issue", 256'(running), 256'(1));
        check("cfg_head", cfg, {8{32'hC0DE_0003}});
        check("running_id0", 256'(running_id), '0);
        step();
        busy = 1'b1;
        cfg_complete = 1'b1;
        #1;
        check("start_single", 256'(start_cfg), '0);
        step();
        finished = 1'b1;
        #1;
        check("running_run", 256'(running), 256'(1));
        step();
        finished = 1'b0;
        busy = 1'b0;
        cfg_complete = 1'b0;
        #1;
        check("done_evt", 256'(evt), 256'(16'h0040));
        check("running_done", 256'(running), '0);
        check("cfg_stable_done", cfg, {8{32'hC0DE_0003}});
        step();
        #1;
        check("done_once", 256'(evt), '0);
        check("occ_empty", 256'(occupancy), '0);

        // Fairness with a controller that never answers
        req_valid = 8'h07;
        #1;
        check("rr0_ready", 256'(req_ready), 256'(8'h01));
        check("rr0_id", 256'(req_id), 256'(1));
        step();
        #1;
        check("rr1_ready", 256'(req_ready), 256'(8'h02));
        check("rr1_id", 256'(req_id), 256'(2));
        step();
        #1;
        check("rr2_ready", 256'(req_ready), 256'(8'h04));
        check("rr2_id", 256'(req_id), 256'(3));
        check("start_b", 256'(start_cfg), 256'(1));
        step();
        #1;
        check("full_ready", 256'(req_ready), '0);
        check("full_occ", 256'(occupancy), 256'(3));
        step(14);
        #1;
        check("retry_not_yet", 256'(start_cfg), '0);
        step();
        #1;
        check("retry_pulse", 256'(start_cfg), 256'(1));
        step();
        busy = 1'b1;
        cfg_complete = 1'b1;
        #1;
        check("retry_once", 256'(start_cfg), '0);
        seen_start = 1'b0;
        repeat (20) begin
            step();
            #1;
            seen_start |= start_cfg;
        end
        check("no_start_in_run", 256'(seen_start), '0);
        check("fair_running", 256'(running), 256'(1));
        check("fair_running_id", 256'(running_id), 256'(1));
        check("fair_cfg", cfg, {8{32'hC0DE_0000}});

        // Pop and push in the same DONE cycle on a full queue
        finished = 1'b1;
        step();
        finished = 1'b0;
        #1;
        check("pushpop_evt", 256'(evt), 256'(16'h0003));
        check("pushpop_ready", 256'(req_ready), 256'(8'h01));
        check("pushpop_id", 256'(req_id), 256'(4));
        check("pushpop_occ_pre", 256'(occupancy), 256'(3));
        step();
        busy = 1'b0;
        cfg_complete = 1'b0;
        #1;
        check("pushpop_occ", 256'(occupancy), 256'(3));
        check("full_again", 256'(req_ready), '0);
        check("id_no_gap", 256'(req_id), 256'(5));
        step();
        #1;
        check("next_start", 256'(start_cfg), 256'(1));
        check("next_running_id", 256'(running_id), 256'(2));
        check("next_cfg", cfg, {8{32'hC0DE_0001}});
        step();
        busy = 1'b1;
        cfg_complete = 1'b1;
        step();
        #1;
        check("run_before_clr", 256'(running), 256'(1));

        // Soft clear mid-job, with a finish and pending requests in the same cycle
        clear = 1'b1;
        finished = 1'b1;
        #1;
        check("clr_ready", 256'(req_ready), '0);
        check("clr_no_acc", 256'(evt), '0);
        step();
        clear = 1'b0;
        finished = 1'b0;
        req_valid = '0;
        busy = 1'b0;
        cfg_complete = 1'b0;
        #1;
        check("clr_occ", 256'(occupancy), '0);
        check("clr_running", 256'(running), '0);
        check("clr_evt", 256'(evt), '0);
        check("clr_running_id", 256'(running_id), '0);
        check("clr_id", 256'(req_id), '0);
        step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        #1;
        check("late_finish_evt", 256'(evt), '0);
        check("late_finish_run", 256'(running), '0);
        check("late_finish_start", 256'(start_cfg), '0);

        // RR pointer back at 0, then run IDs through a full wrap
        run_job(8'h84, 8'h04, 8'd0, 1'b1, "id_first");
        for (int k = 1; k <= 256; k++) begin
            run_job(8'(1 << (k % 8)), '0, 8'(k), 1'b0, (k == 256) ? "id_wrap" : "id_seq");
        end
        check("final_occ", 256'(occupancy), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
